// File: rtl/dac_frame_rx_pkg.sv
// Shared constants and types for the dac_frame_rx receiver.
package dac_frame_rx_pkg;

    // Default frame geometry.
    localparam int DEF_SPI_LEN = 16;
    localparam int DEF_DATA_W  = 12;
    localparam int DEF_NUM_CH  = 8;

    // Width of the channel index / pos output for the default channel count.
    localparam int CH_W = $clog2(DEF_NUM_CH);

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

endpackage

// File: rtl/dac_frame_rx_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus a delay flop.
// It provides the synchronized level (s2) and single-cycle rise/fall strobes.
// RST_VAL sets the idle level all three flops return to on reset.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_s2,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Resample the asynchronous input, then keep one extra delay stage for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_s2   = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/dac_frame_rx.sv
// dac_frame_rx: listening end of the DAC SPI polling link.
// It oversamples sclk/din/sync_n in the clk_core domain and checks each frame's length.
// Each good frame is written into a round-robin channel shadow array.
// Optional build macro DAC_FRAME_RX_ERRCNT_EN adds the err_cnt output, a saturating error counter.
module dac_frame_rx
    import dac_frame_rx_pkg::*;
#(
    parameter int SPI_LEN = DEF_SPI_LEN,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CH  = DEF_NUM_CH
) (
    input  logic                       clk_core,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       sclk,
    input  logic                       din,
    input  logic                       sync_n,
    output logic [DATA_W-1:0]          data_out [0:NUM_CH-1],
    output logic [SPI_LEN-1:0]         word_out,
    output logic                       word_valid,
    output logic                       frame_err,
    output logic [$clog2(NUM_CH)-1:0]  pos,
    output logic                       frame_wrap,
`ifdef DAC_FRAME_RX_ERRCNT_EN
    output logic [7:0]                 err_cnt,
`endif
    output logic [1:0]                 state_dbg
);

    localparam int W_CH = $clog2(NUM_CH);
    localparam int BC_W = $clog2(SPI_LEN + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(SPI_LEN);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(SPI_LEN + 1);
    localparam logic [W_CH-1:0] CH_LAST = W_CH'(NUM_CH - 1);

    // Output strobe semantics: word_valid and frame_err are one-cycle pulses with no back-pressure.
    // The register updates for a good frame (word_out, data_out, pos) are already visible in the pulse cycle.
    // Those values then hold until the next good frame.

    logic w_sclk_s2, w_sclk_rise, w_sclk_fall;
    logic w_din_s2, w_din_rise, w_din_fall;
    logic w_sync_s2, w_sync_rise, w_sync_fall;
    logic w_unused;

    sync_edge_det #(.RST_VAL(1'b1)) u_sync_sclk (
        .i_clk   (clk_core),
        .i_rst_n (rst_n),
        .i_d     (sclk),
        .o_s2    (w_sclk_s2),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sync_din (
        .i_clk   (clk_core),
        .i_rst_n (rst_n),
        .i_d     (din),
        .o_s2    (w_din_s2),
        .o_rise  (w_din_rise),
        .o_fall  (w_din_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_sync_sync (
        .i_clk   (clk_core),
        .i_rst_n (rst_n),
        .i_d     (sync_n),
        .o_s2    (w_sync_s2),
        .o_rise  (w_sync_rise),
        .o_fall  (w_sync_fall)
    );

    // Only din's level and sclk's falling edge matter to the receiver.
    assign w_unused = ^{w_sclk_s2, w_sclk_rise, w_din_rise, w_din_fall};

    rx_state_t          r_state;
    rx_state_t          w_next_state;
    logic [SPI_LEN-1:0] r_shreg;
    logic [BC_W-1:0]    r_bit_cnt;
    logic [W_CH-1:0]    r_ch;
    logic [W_CH-1:0]    r_pos;
    logic [SPI_LEN-1:0] r_word;
    logic [DATA_W-1:0]  r_data [0:NUM_CH-1];
    logic               r_word_valid;
    logic               r_frame_err;
    logic               r_frame_wrap;

    logic w_enter_shift;
    logic w_shift_bit;
    logic w_close;
    logic w_good;

    // State register.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: an abort (en low) takes priority over closing the frame.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_sync_fall && en) w_next_state = SHIFT;
            end
            SHIFT: begin
                if (!en)              w_next_state = IDLE;
                else if (w_sync_rise) w_next_state = CHECK;
            end
            CHECK: begin
                if (w_sync_fall && en) w_next_state = SHIFT;
                else                   w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A sync_rise in the same cycle as an sclk fall closes the frame, so that bit is dropped.
    assign w_enter_shift = (w_next_state == SHIFT) && (r_state != SHIFT);
    assign w_shift_bit   = (r_state == SHIFT) && en && !w_sync_rise && w_sclk_fall && !w_sync_s2;
    assign w_close       = (r_state == SHIFT) && en && w_sync_rise;
    assign w_good        = w_close && (r_bit_cnt == BC_FULL);

    // Shift register and saturating bit counter; a saturated count can never look like a good frame.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_enter_shift) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift_bit) begin
            r_shreg <= {r_shreg[SPI_LEN-2:0], w_din_s2};
            if (r_bit_cnt != BC_SAT) r_bit_cnt <= r_bit_cnt + BC_W'(1);
        end
    end

    // Frame verdict: a good frame is committed as the FSM enters CHECK, and the pulses cover the CHECK cycle.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_wrap <= 1'b0;
            r_word       <= '0;
            r_pos        <= '0;
            r_ch         <= '0;
            for (int i = 0; i < NUM_CH; i++) r_data[i] <= '0;
        end else begin
            r_word_valid <= w_good;
            r_frame_err  <= w_close && !w_good;
            r_frame_wrap <= w_good && (r_ch == CH_LAST);
            if (w_good) begin
                r_word       <= r_shreg;
                r_data[r_ch] <= r_shreg[DATA_W-1:0];
                r_pos        <= r_ch;
                r_ch         <= r_ch + W_CH'(1);
            end
        end
    end

`ifdef DAC_FRAME_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Error counter: saturates at 255 and is held clear while the receiver is disabled.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (!en) begin
            r_err_cnt <= 8'd0;
        end else if (r_frame_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign data_out   = r_data;
    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;
    assign pos        = r_pos;
    assign frame_wrap = r_frame_wrap;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_dac_frame_rx.sv
// Testbench for dac_frame_rx: a frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_dac_frame_rx;
  import dac_frame_rx_pkg::*;

  localparam int SPI_LEN = DEF_SPI_LEN;
  localparam int DATA_W  = DEF_DATA_W;
  localparam int NUM_CH  = DEF_NUM_CH;

  // ---------------- clock / reset ----------------
  logic clk_core = 1'b0;
  logic rst_n    = 1'b0;
  logic en       = 1'b0;
  logic sclk     = 1'b1;
  logic din      = 1'b0;
  logic sync_n   = 1'b1;

  always #5 clk_core = ~clk_core;

  logic [DATA_W-1:0]  data_out [0:NUM_CH-1];
  logic [SPI_LEN-1:0] word_out;
  logic               word_valid;
  logic               frame_err;
  logic [CH_W-1:0]    pos;
  logic               frame_wrap;
  logic [1:0]         state_dbg;
`ifdef DAC_FRAME_RX_ERRCNT_EN
  logic [7:0]         err_cnt;
`endif

  dac_frame_rx dut (
    .clk_core   (clk_core),
    .rst_n      (rst_n),
    .en         (en),
    .sclk       (sclk),
    .din        (din),
    .sync_n     (sync_n),
    .data_out   (data_out),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .pos        (pos),
    .frame_wrap (frame_wrap),
`ifdef DAC_FRAME_RX_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Each sent frame queues its verdict: {good, raw word}.
  logic [SPI_LEN:0]   exp_q[$];
  logic [SPI_LEN:0]   e;
  logic [DATA_W-1:0]  m_shadow [0:NUM_CH-1];
  logic [SPI_LEN-1:0] m_word = '0;
  logic [CH_W-1:0]    m_pos  = '0;
  logic [CH_W-1:0]    m_ch   = '0;
  bit                 chk_en = 1'b0;
  bit                 prev_pulse = 1'b0;
  int                 n_wv = 0;
  int                 n_fe = 0;
  int                 n_wrap = 0;

  // Raw pulse counters, independent of the model.
  always @(negedge clk_core) begin
    if (rst_n) begin
      if (word_valid) n_wv++;
      if (frame_err)  n_fe++;
      if (frame_wrap) n_wrap++;
    end
  end

  // Compare process: verdict on each pulse, register contents on quiet cycles.
  always @(negedge clk_core) begin
    if (chk_en && rst_n) begin
      if (word_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, word_valid, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {30'd0, word_valid, frame_err}, e[SPI_LEN] ? 32'd2 : 32'd1);
          if (e[SPI_LEN]) begin
            check("frame_wrap", {31'd0, frame_wrap}, {31'd0, (m_ch == CH_W'(NUM_CH - 1))});
            m_shadow[m_ch] = e[DATA_W-1:0];
            m_word = e[SPI_LEN-1:0];
            m_pos  = m_ch;
            m_ch   = m_ch + 1'b1;
          end else begin
            check("wrap_on_err", {31'd0, frame_wrap}, 32'd0);
          end
        end
        prev_pulse = 1'b1;
      end else begin
        check("wrap_idle", {31'd0, frame_wrap}, 32'd0);
        if (!prev_pulse) begin
          check("word_out", {16'd0, word_out}, {16'd0, m_word});
          check("pos", {29'd0, pos}, {29'd0, m_pos});
          for (int i = 0; i < NUM_CH; i++)
            check("data_out", {20'd0, data_out[i]}, {20'd0, m_shadow[i]});
        end
        prev_pulse = 1'b0;
      end
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  // One bit: data set with sclk high, sampled by the receiver on the falling edge.
  task automatic spi_bit(input logic b);
    din = b;
    tick(4);
    sclk = 1'b0;
    tick(4);
    sclk = 1'b1;
  endtask

  // Sends w[nbits-1:0] MSB first; returns right after sync_n rises.
  task automatic frame_body(input logic [31:0] w, input int nbits);
    sync_n = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(w[i]);
    tick(4);
    sync_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits, input int gap);
    exp_q.push_back({(nbits == SPI_LEN), w[SPI_LEN-1:0]});
    frame_body(w, nbits);
    tick(gap);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_shadow[i] = '0;
    m_word = '0;
    m_pos  = '0;
    m_ch   = '0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_frame_wrap"}, {31'd0, frame_wrap}, 32'd0);
    check({tag, "_word_out"}, {16'd0, word_out}, 32'd0);
    check({tag, "_pos"}, {29'd0, pos}, 32'd0);
    check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
    for (int i = 0; i < NUM_CH; i++) check({tag, "_data_out"}, {20'd0, data_out[i]}, 32'd0);
`ifdef DAC_FRAME_RX_ERRCNT_EN
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] seq8 [0:7];
  int wv0, fe0;
  int lens [0:8];

  initial begin
    seq8[0] = 16'h0123; seq8[1] = 16'h0456; seq8[2] = 16'h0789; seq8[3] = 16'h0ABC;
    seq8[4] = 16'h0DEF; seq8[5] = 16'h0321; seq8[6] = 16'h0654; seq8[7] = 16'h0FFF;
    lens[0] = 0;  lens[1] = 14; lens[2] = 15; lens[3] = 16; lens[4] = 16;
    lens[5] = 16; lens[6] = 17; lens[7] = 18; lens[8] = 20;
    model_reset();

    // Reset state.
    tick(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    en    = 1'b1;
    tick(2);
    chk_en = 1'b1;

    // Eight frames fill all slots; wrap pulses only on the last.
    for (int i = 0; i < 8; i++) send_frame({16'd0, seq8[i]}, 16, 6);
    tick(4);
    check("seq8_valid_count", n_wv, 8);
    check("seq8_wrap_count", n_wrap, 1);
    check("seq8_pos", {29'd0, pos}, 32'd7);
    check("seq8_slot0", {20'd0, data_out[0]}, 32'h123);
    check("seq8_slot7", {20'd0, data_out[7]}, 32'hFFF);

    // 0xA5C3 and latency: pulse on the 3rd edge after s1 samples sync_n high.
    exp_q.push_back({1'b1, 16'hA5C3});
    frame_body(32'h0000A5C3, 16);
    tick(1);
    check("lat_e1", {31'd0, word_valid}, 32'd0);
    tick(1);
    check("lat_e2", {31'd0, word_valid}, 32'd0);
    tick(1);
    check("lat_e3", {31'd0, word_valid}, 32'd1);
    tick(4);
    check("a5c3_word", {16'd0, word_out}, 32'hA5C3);
    check("a5c3_slot0", {20'd0, data_out[0]}, 32'h5C3);
    check("a5c3_pos", {29'd0, pos}, 32'd0);

    // Bad lengths: 15 and 17 bits.
    wv0 = n_wv;
    fe0 = n_fe;
    send_frame(32'h00007ABC, 15, 6);
    send_frame(32'h0001F00D, 17, 6);
    tick(4);
    check("badlen_err_count", n_fe - fe0, 2);
    check("badlen_valid_count", n_wv - wv0, 0);
    check("badlen_slot1", {20'd0, data_out[1]}, 32'h456);
    check("badlen_pos", {29'd0, pos}, 32'd0);
`ifdef DAC_FRAME_RX_ERRCNT_EN
    check("badlen_err_cnt", {24'd0, err_cnt}, 32'd2);
`endif

    // en dropped after bit 8, frame completed: nothing happens.
    wv0 = n_wv;
    fe0 = n_fe;
    sync_n = 1'b0;
    tick(4);
    for (int i = 15; i >= 8; i--) spi_bit(i[0]);
    en = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(i[0]);
    tick(4);
    sync_n = 1'b1;
    tick(8);
    // Frame starting with en low, en rising mid-frame: also ignored.
    sync_n = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    en = 1'b1;
    for (int i = 0; i < 12; i++) spi_bit(1'b0);
    tick(4);
    sync_n = 1'b1;
    tick(8);
    check("abort_no_pulse", (n_wv - wv0) + (n_fe - fe0), 0);
    send_frame(32'h00000321, 16, 6);
    tick(4);
    check("after_abort_slot1", {20'd0, data_out[1]}, 32'h321);

    // Reset mid-frame after three good frames.
    send_frame(32'h00000111, 16, 6);
    send_frame(32'h00000222, 16, 6);
    send_frame(32'h00000333, 16, 6);
    sync_n = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    sync_n = 1'b1;
    sclk   = 1'b1;
    din    = 1'b0;
    tick(2);
    check_all_zero("midrst");
    model_reset();
    rst_n = 1'b1;
    tick(4);
    chk_en = 1'b1;
    send_frame(32'h00000777, 16, 6);
    tick(4);
    check("postrst_slot0", {20'd0, data_out[0]}, 32'h777);
    check("postrst_pos", {29'd0, pos}, 32'd0);

    // Back-to-back frames at the minimum sync_n gap.
    wv0 = n_wv;
    fe0 = n_fe;
    for (int i = 0; i < 6; i++) send_frame({16'd0, 16'($urandom_range(0, 65535))}, 16, 4);
    tick(8);
    check("b2b_valid_count", n_wv - wv0, 6);
    check("b2b_err_count", n_fe - fe0, 0);

    // Randomized frames: mixed lengths, data and gaps.
    for (int k = 0; k < 40; k++) begin
      send_frame($urandom, lens[$urandom_range(0, 8)], $urandom_range(4, 10));
    end

    tick(20);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_frame_rx.md
Name: dac_frame_rx

Overview:
- SPI frame receiver: the listening end of the DAC polling link (sclk idle high, sync_n framed, MSB first, data valid at the sclk falling edge, 16-bit frames carrying {4'b0, 12-bit code}).
- Oversamples sclk/din/sync_n in the clk_core domain, checks frame length, and writes each good frame into an 8-entry channel shadow array.
- The channel index auto-increments per frame, mirroring the transmitter's round-robin.
- Used as the DAC model/loopback checker on the board and in simulation.

Parameters:
SPI_LEN, 16, bits per frame
DATA_W, 12, payload bits taken from the frame LSBs
NUM_CH, 8, channel slots; must be a power of 2

Ports:
clk_core  in  1  core clock
rst_n  in  1  asynchronous active-low reset
en  in  1  receive enable
sclk  in  1  serial clock, asynchronous to clk_core
din  in  1  serial data, asynchronous to clk_core
sync_n  in  1  frame strobe, active low, asynchronous to clk_core
data_out  out  [DATA_W-1:0] x [0:NUM_CH-1]  channel shadow array
word_out  out  SPI_LEN  last good raw frame
word_valid  out  1  one-cycle pulse when a good frame is captured
frame_err  out  1  one-cycle pulse on a bad-length frame
pos  out  log2(NUM_CH)  channel written by the last good frame
frame_wrap  out  1  one-cycle pulse, coincident with word_valid, when channel NUM_CH-1 is written

Behaviour:
- Reset values: all outputs 0, every data_out entry 0, channel pointer ch=0, state IDLE. Synchronizer flops reset to sclk=1, din=0, sync_n=1.
- Input conditioning: sclk, din and sync_n each pass through 2 flops (s1, s2) plus a delay flop s3. sclk_fall = ~s2 & s3; sync_rise = s2 & ~s3; sync_fall = ~s2 & s3.
- Timing requirement: sclk high and low phases ≥3 clk_core cycles each; sync_n high time between frames ≥4 clk_core cycles.
- States are IDLE, SHIFT and CHECK.
- IDLE -> SHIFT on sync_fall & en. Clear shreg and bit_cnt on entry.
- SHIFT:
  - On sclk_fall with synchronized sync_n low, shift left: shreg <= {shreg[SPI_LEN-2:0], din_s2}.
  - On the same edge, bit_cnt increments, saturating at SPI_LEN+1.
  - sync_rise -> CHECK. sync_rise wins over a same-cycle sclk_fall; that bit is discarded.
  - en low -> IDLE immediately (abort). No valid or err pulse; shadow array and ch unchanged.
- CHECK lasts one cycle:
  - If bit_cnt == SPI_LEN:
    - word_out <= shreg; data_out[ch] <= shreg[DATA_W-1:0]; pos <= ch; ch <= ch+1, wrapping NUM_CH-1 -> 0.
    - word_valid = 1. frame_wrap = 1 if ch == NUM_CH-1.
    - Upper SPI_LEN-DATA_W bits are ignored.
  - Else: frame_err = 1; no other register changes.
  - Next state is SHIFT if sync_fall & en this cycle, else IDLE.
- Latency: word_valid/frame_err go high on the 3rd clk_core edge after the first edge that samples sync_n high at s1.
- data_out, word_out and pos hold their values until the next good frame.
- Frame with bit_cnt ≥ SPI_LEN+1 (saturated): flagged as error, never aliases to good.
- Frame with 0 bits (sync_n pulse without clocks): frame_err.
- sync_n low while en is low: ignored entirely, including if en rises mid-frame. A frame starts only on a sync_fall seen with en high.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.

Optional Feature:
- DAC_FRAME_RX_ERRCNT_EN defined: adds output err_cnt [7:0], reset 0.
  - Increments on each frame_err pulse, saturating at 255.
  - Clears synchronously while en is low.
- Not defined: no err_cnt port and no counter logic.

Decomposition:
- Package dac_frame_rx_pkg holds:
  - SPI_LEN, DATA_W and NUM_CH defaults.
  - The state enum typedef (IDLE, SHIFT, CHECK).
  - The channel index width constant, log2(NUM_CH).
- One sub-module, sync_edge_det: 2-flop synchronizer plus delay flop with rise/fall outputs and a reset-value parameter. It is instantiated for sclk, din and sync_n; for din only s2 is used.

Test Plan:
- Send 8 frames 0x0123, 0x0456 … 0x0FFF with en=1 -> 8 word_valid pulses; pos 0..7; data_out[0]=12'h123, data_out[7]=12'hFFF; frame_wrap only on the 8th.
- Send frame 0xA5C3 -> word_out=16'hA5C3, data_out[ch]=12'h5C3. Measure latency -> word_valid exactly 3 edges after s1 samples sync_n high.
- Send a 15-bit frame, then a 17-bit frame -> two frame_err pulses, no word_valid, ch and data_out unchanged. With DAC_FRAME_RX_ERRCNT_EN -> err_cnt=2.
- Drop en after bit 8 of a frame, then complete the frame -> no pulses. Raise en, send 0x0321 -> data_out[ch]=12'h321.
- Assert rst_n low mid-frame after 3 good frames -> all outputs and data_out 0, ch=0. The next good frame writes slot 0.
- Back-to-back frames with the minimum 4-cycle sync_n gap -> every frame captured, no errors.
